// File: rtl/mod_exp_pkg.sv
// Shared definitions for the modular exponentiation engine.
//   state_e   : controller state encoding
//   key_width : operand width derived from the prime width (KW = 2*WIDTH)
package mod_exp_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StReduce = 3'd1,
    StMul    = 3'd2,
    StSqr    = 3'd3,
    StDone   = 3'd4
  } state_e;

  function automatic int unsigned key_width(int unsigned prime_width);
    return 2 * prime_width;
  endfunction

endpackage

// File: rtl/mod_exp_div.sv
// Combinational restoring divider.
//   dividend_i  : W-bit dividend
//   divisor_i   : W-bit divisor (zero divisor yields all-ones quotient, remainder = dividend)
//   quotient_o  : W-bit quotient
//   remainder_o : W-bit remainder
module mod_exp_div #(
  parameter int unsigned W = 128
) (
  input  logic [W-1:0] dividend_i,
  input  logic [W-1:0] divisor_i,
  output logic [W-1:0] quotient_o,
  output logic [W-1:0] remainder_o
);

  // One extra bit so the shifted partial remainder can never overflow before the compare.
  logic [W:0]   rem;
  logic [W-1:0] quo;

  always_comb begin
    rem = '0;
    quo = '0;
    for (int i = int'(W) - 1; i >= 0; i--) begin
      rem = {rem[W-1:0], dividend_i[i]};
      if (rem >= {1'b0, divisor_i}) begin
        rem    = rem - {1'b0, divisor_i};
        quo[i] = 1'b1;
      end
    end
  end

  assign quotient_o  = quo;
  assign remainder_o = rem[W-1:0];

endmodule

// File: rtl/mod_exp.sv
// Modular exponentiation: result = base^exponent mod modulus, right-to-left
// square-and-multiply around a single shared multiply-reduce datapath.
//   clk_i       : clock, rising edge
//   rst_ni      : asynchronous active-low reset
//   start_i     : request, sampled only in idle or done
//   base_i      : message / ciphertext word (KW bits)
//   exponent_i  : e or d (KW bits)
//   modulus_i   : n = p*q (KW bits)
//   busy_o      : operation in progress
//   done_o      : result valid, held until the next accepted start
//   err_o       : latched modulus was zero
//   result_o    : final value (KW bits)
module mod_exp
  import mod_exp_pkg::*;
#(
  parameter  int unsigned WIDTH = 32,
  localparam int unsigned KW    = key_width(WIDTH)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          start_i,
  input  logic [KW-1:0] base_i,
  input  logic [KW-1:0] exponent_i,
  input  logic [KW-1:0] modulus_i,
  output logic          busy_o,
  output logic          done_o,
  output logic          err_o,
  output logic [KW-1:0] result_o
);

  localparam int unsigned PW = 2 * KW;

  state_e        state_q;
  logic [KW-1:0] b_q, e_q, n_q, acc_q, result_q;
  logic          busy_q, done_q, err_q;

  logic [PW-1:0] div_in;
  logic [PW-1:0] div_quo;
  logic [PW-1:0] div_rem;
  logic [KW-1:0] red;

  // Full-precision products; the divider input is selected by the current phase so that
  // exactly one reduction happens per cycle.
  always_comb begin
    div_in = PW'(b_q);
    unique case (state_q)
      StMul:   div_in = PW'(acc_q) * PW'(b_q);
      StSqr:   div_in = PW'(b_q) * PW'(b_q);
      default: div_in = PW'(b_q);
    endcase
  end

  mod_exp_div #(
    .W(PW)
  ) u_div (
    .dividend_i (div_in),
    .divisor_i  (PW'(n_q)),
    .quotient_o (div_quo),
    .remainder_o(div_rem)
  );

  // Remainder is below n_q, so the upper half is always zero.
  assign red = div_rem[KW-1:0];

  logic unused_div;
  assign unused_div = ^{div_quo, div_rem[PW-1:KW]};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      b_q      <= '0;
      e_q      <= '0;
      n_q      <= '0;
      acc_q    <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (start_i) begin
            b_q   <= base_i;
            e_q   <= exponent_i;
            n_q   <= modulus_i;
            acc_q <= (modulus_i == KW'(1)) ? '0 : KW'(1);
            if (modulus_i == '0) begin
              // Nothing to compute: report the error straight away.
              err_q    <= 1'b1;
              result_q <= '0;
              done_q   <= 1'b1;
              busy_q   <= 1'b0;
              state_q  <= StDone;
            end else begin
              err_q   <= 1'b0;
              done_q  <= 1'b0;
              busy_q  <= 1'b1;
              state_q <= StReduce;
            end
          end
        end
        StReduce: begin
          // Base is not assumed to be below n on input.
          b_q     <= red;
          state_q <= StMul;
        end
        StMul: begin
          if (e_q == '0) begin
            result_q <= acc_q;
            done_q   <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= StDone;
          end else begin
            if (e_q[0]) begin
              acc_q <= red;
            end
            state_q <= StSqr;
          end
        end
        StSqr: begin
          b_q     <= red;
          e_q     <= e_q >> 1;
          state_q <= StMul;
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign err_o    = err_q;
  assign result_o = result_q;

endmodule

// File: tb/tb_mod_exp.sv
module tb_mod_exp;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned KW    = 2 * WIDTH;

  typedef logic [KW-1:0] word_t;

  typedef struct {
    word_t result;
    logic  err;
    int    start_cyc;
    int    lat;
  } exp_t;

  logic  clk;
  logic  rst_n;
  logic  start;
  word_t base, exponent, modulus;
  logic  busy, done, err;
  word_t result;

  exp_t exp_q[$];
  int   vectors;
  int   miscompares;
  int   cyc;

  mod_exp #(
    .WIDTH(WIDTH)
  ) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .start_i   (start),
    .base_i    (base),
    .exponent_i(exponent),
    .modulus_i (modulus),
    .busy_o    (busy),
    .done_o    (done),
    .err_o     (err),
    .result_o  (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: left-to-right binary exponentiation on wide integers.
  function automatic word_t ref_modexp(word_t b, word_t e, word_t n);
    logic [2*KW-1:0] r, bb, nn;
    if (n == '0) return '0;
    nn = {{KW{1'b0}}, n};
    r  = 1 % nn;
    bb = {{KW{1'b0}}, b} % nn;
    for (int i = KW - 1; i >= 0; i--) begin
      r = (r * r) % nn;
      if (e[i]) r = (r * bb) % nn;
    end
    return r[KW-1:0];
  endfunction

  // Edges from the start-sampling edge (counted as 1) until done is visible.
  function automatic int ref_lat(word_t e, word_t n);
    int h;
    if (n == '0) return -1;
    if (e == '0) return 3;
    h = 0;
    for (int i = 0; i < KW; i++) if (e[i]) h = i;
    return 2 * h + 5;
  endfunction

  task automatic check(string name, logic [KW-1:0] act, logic [KW-1:0] want);
    vectors++;
    if (act !== want) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, want, $time);
    end
  endtask

  task automatic issue(word_t b, word_t e, word_t n, word_t want);
    exp_t x;
    @(negedge clk);
    base        = b;
    exponent    = e;
    modulus     = n;
    start       = 1'b1;
    x.result    = want;
    x.err       = (n == '0);
    x.start_cyc = cyc + 1;
    x.lat       = ref_lat(e, n);
    exp_q.push_back(x);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain(int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL timeout: %0d results outstanding after %0d cycles", exp_q.size(), budget);
      exp_q.delete();
    end
  endtask

  // Monitor: samples 1 time unit after each rising edge.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (rst_n && exp_q.size() != 0 && cyc >= exp_q[0].start_cyc) begin
        if (done) begin
          x = exp_q.pop_front();
          check("result", result, x.result);
          check("err", KW'(err), KW'(x.err));
          check("busy_in_done", KW'(busy), '0);
          if (x.lat >= 0) check("latency", KW'(cyc - x.start_cyc + 1), KW'(x.lat));
        end else begin
          check("busy_running", KW'(busy), KW'(1));
        end
      end
    end
  end

  initial begin
    word_t b, e, n;
    vectors     = 0;
    miscompares = 0;
    cyc         = 0;
    start       = 1'b0;
    base        = '0;
    exponent    = '0;
    modulus     = '0;
    rst_n       = 1'b0;
    #12;
    check("rst_busy", KW'(busy), '0);
    check("rst_done", KW'(done), '0);
    check("rst_err", KW'(err), '0);
    check("rst_result", result, '0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases with hand-computed answers.
    issue(64'd4, 64'd13, 64'd497, 64'd445);
    drain(200);
    issue(64'd65, 64'd17, 64'd3233, 64'd2790);
    drain(200);
    issue(64'd2790, 64'd2753, 64'd3233, 64'd65);
    drain(200);
    issue(64'd123, 64'd0, 64'd3233, 64'd1);
    drain(200);
    issue(64'd123, 64'd0, 64'd1, 64'd0);
    drain(200);
    issue(64'd77, 64'd9, 64'd1, 64'd0);
    drain(200);
    issue(64'd5000, 64'd1, 64'd3233, 64'd1767);
    drain(200);
    issue(64'd5, 64'd3, 64'd0, 64'd0);
    drain(200);
    issue(64'd4, 64'd13, 64'd497, 64'd445);
    drain(200);

    // Start while busy must be ignored.
    issue(64'd4, 64'd13, 64'd497, 64'd445);
    repeat (2) @(negedge clk);
    base     = 64'd7;
    exponent = 64'd3;
    modulus  = 64'd11;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain(200);
    // Restart from done.
    issue(64'd65, 64'd17, 64'd3233, 64'd2790);
    drain(200);

    // Asynchronous reset while squaring.
    issue(64'd65, 64'd2753, 64'd3233, 64'd0);
    @(posedge clk);
    @(posedge clk);
    #3;
    exp_q.delete();
    rst_n = 1'b0;
    #1;
    check("arst_busy", KW'(busy), '0);
    check("arst_done", KW'(done), '0);
    check("arst_result", result, '0);
    @(negedge clk);
    rst_n = 1'b1;
    issue(64'd2790, 64'd2753, 64'd3233, 64'd65);
    drain(200);

    // Randomized operands of varying magnitude.
    for (int k = 0; k < 40; k++) begin
      n = {$urandom, $urandom} >> $urandom_range(0, 63);
      if (k % 13 == 5) n = '0;
      b = {$urandom, $urandom} >> $urandom_range(0, 63);
      e = {$urandom, $urandom} >> $urandom_range(0, 64);
      issue(b, e, n, ref_modexp(b, e, n));
      drain(300);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
